// File: rtl/voice_mixer.sv
// voice_mixer
//   Output stage for the oscillator stack. Once per sample period the enabled
//   square-wave voices are counted, the count is scaled by a master gain that
//   ramps one step per sample toward the requested volume, and the result is
//   turned into a 1-bit pulse-density stream by a first-order sigma-delta loop.
//
// Ports
//   clk_i         system clock
//   nrst_i        asynchronous active-low reset
//   oscIn_i       per-voice square waves (VOICES bits)
//   voiceEn_i     per-voice enable mask, 1 = voice contributes
//   volume_i      target master gain 0..15
//   audio_o       registered PDM audio bit
//   sampleStrb_o  one-cycle pulse in the cycle new mix/gain first appear
//   active_o      high while the latched mix is non-zero

`ifndef OSC_VOICES
`define OSC_VOICES 8
`endif

module voice_mixer #(
   parameter int VOICES     = `OSC_VOICES,
   parameter int SAMPLE_DIV = 16
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic [VOICES-1:0] oscIn_i,
   input  logic [VOICES-1:0] voiceEn_i,
   input  logic [3:0]        volume_i,
   output logic              audio_o,
   output logic              sampleStrb_o,
   output logic              active_o
);

   localparam int FS     = VOICES * 15;
   localparam int MIX_W  = $clog2(VOICES + 1);
   localparam int PROD_W = $clog2(FS + 1);
   // sum of a residue (<FS) and a product (<=FS) never exceeds 2*FS-1
   localparam int ACC_W  = $clog2(2 * FS);
   localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [CNT_W-1:0]  r_cnt;
   logic [MIX_W-1:0]  r_mix;
   logic [3:0]        r_gain;
   logic [ACC_W-1:0]  r_acc;
   logic              r_audio;
   logic              r_strb;
   logic              r_active;

   logic              w_tick;
   logic [VOICES-1:0] w_masked;
   logic [MIX_W-1:0]  w_pop;
   logic [PROD_W-1:0] w_product;
   logic [ACC_W-1:0]  w_sum;
   logic              w_full;

   assign w_tick   = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
   assign w_masked = oscIn_i & voiceEn_i;

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < VOICES; i++) begin
         w_pop = w_pop + MIX_W'(w_masked[i]);
      end
   end

   assign w_product = PROD_W'(r_mix) * PROD_W'(r_gain);
   assign w_sum     = r_acc + ACC_W'(w_product);
   assign w_full    = (w_sum >= ACC_W'(FS));

   // sample-rate section: divider, mix latch and gain ramp
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         r_cnt    <= '0;
         r_mix    <= '0;
         r_gain   <= '0;
         r_strb   <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_strb <= w_tick;
         if (w_tick) begin
            r_cnt    <= '0;
            r_mix    <= w_pop;
            r_active <= (w_pop != '0);
            if (r_gain < volume_i) begin
               r_gain <= r_gain + 4'd1;
            end else if (r_gain > volume_i) begin
               r_gain <= r_gain - 4'd1;
            end
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // sigma-delta runs every clock; a zero product leaves the residue untouched
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         r_acc   <= '0;
         r_audio <= 1'b0;
      end else if (w_full) begin
         r_acc   <= w_sum - ACC_W'(FS);
         r_audio <= 1'b1;
      end else begin
         r_acc   <= w_sum;
         r_audio <= 1'b0;
      end
   end

   assign audio_o      = r_audio;
   assign sampleStrb_o = r_strb;
   assign active_o     = r_active;

endmodule

// File: tb/tb_voice_mixer.sv
module tb_voice_mixer;

   localparam int V  = 8;
   localparam int SD = 4;
   localparam int FS = V * 15;

   logic         clk_i = 1'b0;
   logic         nrst_i = 1'b1;
   logic [V-1:0] oscIn_i = '0;
   logic [V-1:0] voiceEn_i = '0;
   logic [3:0]   volume_i = '0;
   logic         audio_o;
   logic         sampleStrb_o;
   logic         active_o;

   int total = 0;
   int bad   = 0;

   voice_mixer #(.VOICES(V), .SAMPLE_DIV(SD)) dut (
      .clk_i        (clk_i),
      .nrst_i       (nrst_i),
      .oscIn_i      (oscIn_i),
      .voiceEn_i    (voiceEn_i),
      .volume_i     (volume_i),
      .audio_o      (audio_o),
      .sampleStrb_o (sampleStrb_o),
      .active_o     (active_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: sample clock from edge count, output bit from the running
   // total of products -- a 1 is emitted whenever that total crosses a
   // multiple of full scale, which is exactly density product/FS.
   int m_edges, m_mix, m_gain, m_total;
   bit m_audio, m_strb;

   always @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         m_edges <= 0; m_mix <= 0; m_gain <= 0; m_total <= 0;
         m_audio <= 1'b0; m_strb <= 1'b0;
      end else begin
         m_edges <= m_edges + 1;
         m_total <= m_total + m_mix * m_gain;
         m_audio <= ((m_total + m_mix * m_gain) / FS) != (m_total / FS);
         m_strb  <= ((m_edges % SD) == SD - 1);
         if ((m_edges % SD) == SD - 1) begin
            m_mix <= $countones(oscIn_i & voiceEn_i);
            if (m_gain < int'(volume_i))      m_gain <= m_gain + 1;
            else if (m_gain > int'(volume_i)) m_gain <= m_gain - 1;
         end
      end
   end

   task automatic wait_strobe(input bit rnd_osc, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 64; n++) begin
         @(negedge clk_i);
         if (rnd_osc) oscIn_i = V'($urandom);
         if (sampleStrb_o) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk_i);
      nrst_i = 1'b0;
      @(negedge clk_i);
      nrst_i = 1'b1;
   endtask

   task automatic test_reset();
      int n;
      nrst_i = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_i);
         oscIn_i = V'($urandom); voiceEn_i = V'($urandom); volume_i = 4'($urandom);
         total++;
         if ({audio_o, sampleStrb_o, active_o} !== 3'b000) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%b expected=000", c, {audio_o, sampleStrb_o, active_o});
         end
      end
      oscIn_i = '1; voiceEn_i = '1; volume_i = 4'd15;
      nrst_i = 1'b1;
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!sampleStrb_o && n < 20);
      total++;
      if (n !== SD) begin
         bad++;
         $display("FAIL first_strobe got=%0d cycles expected=%0d", n, SD);
      end
   endtask

   task automatic test_soft_start();
      bit ok;
      oscIn_i = '1; voiceEn_i = '1; volume_i = 4'd15;
      apply_reset();
      for (int k = 1; k <= 15; k++) begin
         wait_strobe(1'b0, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL ramp_strobe_timeout tick=%0d", k); end
         total++;
         if (dut.r_gain !== 4'(k)) begin
            bad++;
            $display("FAIL ramp_gain tick=%0d got=%0d expected=%0d", k, dut.r_gain, k);
         end
         total++;
         if (active_o !== 1'b1) begin
            bad++;
            $display("FAIL ramp_active tick=%0d got=%b expected=1", k, active_o);
         end
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         total++;
         if (audio_o !== 1'b1) begin
            bad++;
            $display("FAIL full_scale cyc=%0d got=%b expected=1", c, audio_o);
         end
      end
   endtask

   task automatic test_half_scale();
      bit ok, prev;
      int ones;
      oscIn_i = 8'h0F; voiceEn_i = '1; volume_i = 4'd15;
      wait_strobe(1'b0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL half_strobe_timeout"); end
      @(negedge clk_i);
      prev = audio_o;
      ones = int'(audio_o);
      for (int c = 1; c < 16; c++) begin
         @(negedge clk_i);
         total++;
         if (audio_o !== ~prev || audio_o !== m_audio) begin
            bad++;
            $display("FAIL half_alternate cyc=%0d got=%b expected=%b", c, audio_o, ~prev);
         end
         prev = audio_o;
         ones += int'(audio_o);
      end
      total++;
      if (ones != 8) begin
         bad++;
         $display("FAIL half_density got=%0d ones expected=8", ones);
      end
   endtask

   task automatic test_mute();
      bit ok;
      voiceEn_i = '0;
      wait_strobe(1'b1, ok);
      total++;
      if (!ok || active_o !== 1'b0) begin
         bad++;
         $display("FAIL mute_active got=%b expected=0 strobe_seen=%b", active_o, ok);
      end
      for (int c = 0; c < 20; c++) begin
         @(negedge clk_i);
         oscIn_i = V'($urandom);
         total++;
         if (audio_o !== 1'b0) begin
            bad++;
            $display("FAIL mute_audio cyc=%0d got=%b expected=0", c, audio_o);
         end
      end
   endtask

   task automatic test_redirect();
      bit ok, found;
      int exp_g[3] = '{11, 10, 10};
      voiceEn_i = '1; volume_i = 4'd0;
      found = 1'b0;
      for (int t = 0; t < 10 && !found; t++) begin
         wait_strobe(1'b1, ok);
         if (ok && dut.r_gain == 4'd12) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL redirect_reach12 got=%0d expected=12", dut.r_gain); end
      volume_i = 4'd10;
      for (int t = 0; t < 3; t++) begin
         wait_strobe(1'b1, ok);
         total++;
         if (!ok || dut.r_gain !== 4'(exp_g[t])) begin
            bad++;
            $display("FAIL redirect_gain step=%0d got=%0d expected=%0d", t, dut.r_gain, exp_g[t]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         total++;
         if (audio_o !== m_audio || sampleStrb_o !== m_strb || active_o !== (m_mix != 0)) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b%b%b expected=%b%b%b", c,
                     audio_o, sampleStrb_o, active_o, m_audio, m_strb, (m_mix != 0));
         end
         oscIn_i = V'($urandom);
         if ($urandom_range(0, 7) == 0) voiceEn_i = V'($urandom);
         if ($urandom_range(0, 15) == 0) volume_i = 4'($urandom);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, found;
      oscIn_i = '1; voiceEn_i = '1; volume_i = 4'd15;
      apply_reset();
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         @(negedge clk_i);
         if (audio_o && dut.r_gain == 4'd15) found = 1'b1;
      end
      total++;
      if (!found) begin bad++; $display("FAIL midreset_reach_full got=%b expected=1", audio_o); end
      @(posedge clk_i);
      #2 nrst_i = 1'b0;
      #1;
      total++;
      if ({audio_o, sampleStrb_o, active_o} !== 3'b000) begin
         bad++;
         $display("FAIL midreset_async got=%b expected=000", {audio_o, sampleStrb_o, active_o});
      end
      @(negedge clk_i);
      nrst_i = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         wait_strobe(1'b0, ok);
         total++;
         if (!ok || dut.r_gain !== 4'(k)) begin
            bad++;
            $display("FAIL midreset_ramp tick=%0d got=%0d expected=%0d", k, dut.r_gain, k);
         end
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_soft_start();
      test_half_scale();
      test_mute();
      test_redirect();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
